rtc_bus_arbiter: RTL and testbench

- Parametrised successor to the single write/read strobe selector on the RTC parallel bus (CS/RD/WR/AD).
- Arbitrates N_CH bus-master sequencers (write sequencer, read sequencer, future init/burst sequencers) with round-robin grants.
- Forwards only the granted channel's strobes and AD drive.
- Registers all bus outputs and inserts idle turnaround cycles between owners, so strobes never glitch or overlap.

---
 rtl/rtc_bus_arbiter_pkg.sv | 22 ++
 rtl/rtc_bus_arbiter_if.sv | 41 ++++
 rtl/rtc_bus_arbiter_rr_arbiter.sv | 28 ++
 rtl/rtc_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared types and constants for the RTC parallel-bus arbiter.
// Holds the FSM encoding, the bus idle levels and the pointer width helper.
package rtc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic CS_N_IDLE  = 1'b1;
  localparam logic RD_N_IDLE  = 1'b1;
  localparam logic WR_N_IDLE  = 1'b1;
  localparam logic AD_IDLE    = 1'b0;
  localparam logic AD_OE_IDLE = 1'b0;

  // Index width for an N-entry one-hot vector; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Bundle of per-channel sequencer signals and the shared RTC bus pins.
// The arbiter takes the slave view; the sequencers/bench take the master view.
interface rtc_bus_arbiter_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 8
);
  import rtc_bus_pkg::*;

  // Handshake: a channel raises req[k] and holds it for the whole transaction.
  // It may drive strobes/AD only while gnt[k] is high; dropping req ends the
  // transaction and gnt[k] falls on the next edge.
  logic [N_CH-1:0]        req;
  logic [N_CH-1:0]        cs_n_in;
  logic [N_CH-1:0]        rd_n_in;
  logic [N_CH-1:0]        wr_n_in;
  logic [N_CH*DATA_W-1:0] ad_in;
  logic [N_CH-1:0]        ad_oe_in;

  logic [N_CH-1:0]        gnt;
  logic                   cs_n_out;
  logic                   rd_n_out;
  logic                   wr_n_out;
  logic [DATA_W-1:0]      ad_out;
  logic                   ad_oe_out;
  logic                   busy;
  logic                   viol;
  state_t                 dbg_state;

  modport slave (
    input  req, cs_n_in, rd_n_in, wr_n_in, ad_in, ad_oe_in,
    output gnt, cs_n_out, rd_n_out, wr_n_out, ad_out, ad_oe_out, busy, viol,
    output dbg_state
  );

  modport master (
    output req, cs_n_in, rd_n_in, wr_n_in, ad_in, ad_oe_in,
    input  gnt, cs_n_out, rd_n_out, wr_n_out, ad_out, ad_oe_out, busy, viol,
    input  dbg_state
  );

endinterface

// File: rtl/rtc_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping modulo N_CH.
module rr_arbiter #(
  parameter int N_CH  = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_CH-1:0]  win_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % N_CH);
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin owner arbitration for the RTC CS/RD/WR/AD bus with registered
// pins, forced idle turnaround between owners and a sticky violation flag.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int DATA_W = 8,
  parameter int TURN   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  rtc_bus_arbiter_if.slave  bus
);

  localparam int         PTR_W     = ptr_width(N_CH);
  localparam logic [3:0] TURN_LOAD = (TURN > 0) ? 4'(TURN - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_CH-1:0]   gnt_q, gnt_d;
  logic              cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [DATA_W-1:0] ad_q, ad_d;
  logic              ad_oe_q, ad_oe_d;
  logic              viol_q, viol_d;

  logic [N_CH-1:0]   win_oh;
  logic              win_valid;
  logic [PTR_W-1:0]  win_idx;
  logic              owner_req;
  logic              cs_sel, rd_sel, wr_sel, oe_sel;
  logic [DATA_W-1:0] ad_sel;
  logic              stray, both_low;

  rr_arbiter #(.N_CH(N_CH), .PTR_W(PTR_W)) u_rr (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .win_o   (win_oh),
    .valid_o (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (win_oh[k]) win_idx = PTR_W'(k);
    end
  end

  assign owner_req = |(bus.req & gnt_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cs_n_q  <= CS_N_IDLE;
      rd_n_q  <= RD_N_IDLE;
      wr_n_q  <= WR_N_IDLE;
      ad_q    <= {DATA_W{AD_IDLE}};
      ad_oe_q <= AD_OE_IDLE;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      ad_q    <= ad_d;
      ad_oe_q <= ad_oe_d;
      viol_q  <= viol_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_GRANT;
          gnt_d   = win_oh;
          ptr_d   = PTR_W'((int'(win_idx) + 1) % N_CH);
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          gnt_d   = '0;
          state_d = (TURN == 0) ? ST_IDLE : ST_TURN;
          cnt_d   = TURN_LOAD;
        end
      end
      ST_TURN: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : outputs
    cs_sel = CS_N_IDLE;
    rd_sel = RD_N_IDLE;
    wr_sel = WR_N_IDLE;
    ad_sel = {DATA_W{AD_IDLE}};
    oe_sel = AD_OE_IDLE;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_q[k]) begin
        cs_sel = bus.cs_n_in[k];
        rd_sel = bus.rd_n_in[k];
        wr_sel = bus.wr_n_in[k];
        ad_sel = bus.ad_in[k*DATA_W +: DATA_W];
        oe_sel = bus.ad_oe_in[k];
      end
    end

    cs_n_d  = CS_N_IDLE;
    rd_n_d  = RD_N_IDLE;
    wr_n_d  = WR_N_IDLE;
    ad_d    = {DATA_W{AD_IDLE}};
    ad_oe_d = AD_OE_IDLE;
    // Only a continuing owner reaches the pins; a releasing owner is forced idle.
    if (state_q == ST_GRANT && owner_req) begin
      cs_n_d  = cs_sel;
      ad_d    = ad_sel;
      ad_oe_d = oe_sel;
      if (rd_sel || wr_sel) begin
        rd_n_d = rd_sel;
        wr_n_d = wr_sel;
      end
    end

    stray    = |(~gnt_q & (~bus.rd_n_in | ~bus.wr_n_in | bus.ad_oe_in));
    both_low = |(gnt_q & ~bus.rd_n_in & ~bus.wr_n_in);
    viol_d   = viol_q | stray | both_low;
  end

  assign bus.gnt       = gnt_q;
  assign bus.cs_n_out  = cs_n_q;
  assign bus.rd_n_out  = rd_n_q;
  assign bus.wr_n_out  = wr_n_q;
  assign bus.ad_out    = ad_q;
  assign bus.ad_oe_out = ad_oe_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.viol      = viol_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: a 2-channel TURN=2 instance and a
// 4-channel TURN=0 instance sharing clock and reset.
module tb_rtc_bus_arbiter;
  import rtc_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rtc_bus_arbiter_if #(.N_CH(2), .DATA_W(8)) ifa ();
  rtc_bus_arbiter_if #(.N_CH(4), .DATA_W(8)) ifb ();

  rtc_bus_arbiter #(.N_CH(2), .DATA_W(8), .TURN(2)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  rtc_bus_arbiter #(.N_CH(4), .DATA_W(8), .TURN(0)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_a();
    ifa.req      = '0;
    ifa.cs_n_in  = '1;
    ifa.rd_n_in  = '1;
    ifa.wr_n_in  = '1;
    ifa.ad_in    = '0;
    ifa.ad_oe_in = '0;
  endtask

  task automatic idle_b();
    ifb.req      = '0;
    ifb.cs_n_in  = '1;
    ifb.rd_n_in  = '1;
    ifb.wr_n_in  = '1;
    ifb.ad_in    = '0;
    ifb.ad_oe_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_a();
    idle_b();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_bus_idle_a(input string tag);
    check({tag, "_cs"}, 32'(ifa.cs_n_out), 32'd1);
    check({tag, "_rd"}, 32'(ifa.rd_n_out), 32'd1);
    check({tag, "_wr"}, 32'(ifa.wr_n_out), 32'd1);
    check({tag, "_ad"}, 32'(ifa.ad_out), 32'd0);
    check({tag, "_oe"}, 32'(ifa.ad_oe_out), 32'd0);
  endtask

  task automatic wait_gnt_a(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.gnt != 2'b00) break;
    end
    check(tag, 32'(ifa.gnt), 32'(exp));
  endtask

  task automatic wait_idle_a(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ifa.busy) break;
    end
    check(tag, 32'(ifa.busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         low_cnt;
    int         held;
    logic [1:0] g, prev, req_v;

    reset_n = 1'b0;
    idle_a();
    idle_b();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_gnt", 32'(ifa.gnt), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_viol", 32'(ifa.viol), 32'd0);
    check("rst_state", 32'(ifa.dbg_state), 32'(ST_IDLE));
    check("rst_gnt_b", 32'(ifb.gnt), 32'd0);
    check_bus_idle_a("rst");
    reset_n = 1'b1;

    // Single write on ch0
    ifa.req[0] = 1'b1;
    @(negedge clk);
    check("wr_gnt", 32'(ifa.gnt), 32'd1);
    check("wr_busy", 32'(ifa.busy), 32'd1);
    check("wr_not_yet", 32'(ifa.wr_n_out), 32'd1);
    ifa.cs_n_in[0]  = 1'b0;
    ifa.wr_n_in[0]  = 1'b0;
    ifa.ad_in[7:0]  = 8'hA5;
    ifa.ad_oe_in[0] = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) check("wr_first_low", 32'(ifa.wr_n_out), 32'd0);
      if (!ifa.wr_n_out) low_cnt++;
      if (ifa.ad_oe_out) check("wr_ad", 32'(ifa.ad_out), 32'hA5);
      if (i == 2) begin
        ifa.cs_n_in[0]  = 1'b1;
        ifa.wr_n_in[0]  = 1'b1;
        ifa.ad_in[7:0]  = 8'h00;
        ifa.ad_oe_in[0] = 1'b0;
      end
    end
    check("wr_low_cycles", 32'(low_cnt), 32'd3);
    ifa.req[0] = 1'b0;
    @(negedge clk);
    check("wr_rel_gnt", 32'(ifa.gnt), 32'd0);
    check("wr_rel_state", 32'(ifa.dbg_state), 32'(ST_TURN));
    check_bus_idle_a("wr_rel");
    wait_idle_a("wr_idle");
    check("wr_viol", 32'(ifa.viol), 32'd0);

    // Asynchronous reset mid-GRANT
    ifa.req[0] = 1'b1;
    wait_gnt_a("ar_gnt", 2'b01);
    ifa.wr_n_in[0] = 1'b0;
    @(negedge clk);
    check("ar_pre_wr", 32'(ifa.wr_n_out), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("ar_wr", 32'(ifa.wr_n_out), 32'd1);
    check("ar_gnt0", 32'(ifa.gnt), 32'd0);
    check("ar_busy", 32'(ifa.busy), 32'd0);
    check("ar_state", 32'(ifa.dbg_state), 32'(ST_IDLE));
    idle_a();
    @(negedge clk);
    reset_n = 1'b1;

    // Contention from pointer 0, TURN=2 gap
    ifa.req = 2'b11;
    @(negedge clk);
    check("ct_first", 32'(ifa.gnt), 32'd1);
    ifa.req[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ct_gap", 32'(ifa.gnt), 32'd0);
    end
    check("ct_arb_state", 32'(ifa.dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    check("ct_second", 32'(ifa.gnt), 32'd2);
    ifa.req[1] = 1'b0;
    wait_idle_a("ct_idle");

    // Round robin with both channels repeatedly requesting
    exp_q = {32'd1, 32'd2, 32'd1, 32'd2};
    ifa.req = 2'b11;
    prev = 2'b00;
    held = 0;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      g = ifa.gnt;
      check("rr_onehot", 32'(g & (g - 2'd1)), 32'd0);
      if (g != 2'b00 && prev == 2'b00) check("rr_order", 32'(g), exp_q.pop_front());
      prev  = g;
      req_v = 2'b11;
      if (g != 2'b00) begin
        held++;
        if (held >= 2) begin
          req_v = ~g;
          held  = 0;
        end
      end else begin
        held = 0;
      end
      ifa.req = req_v;
    end
    check("rr_done", 32'(exp_q.size()), 32'd0);
    ifa.req = 2'b00;
    wait_idle_a("rr_idle");

    // Forced release: owner drops req while its strobe is low
    ifa.req = 2'b01;
    wait_gnt_a("fr_gnt", 2'b01);
    ifa.wr_n_in[0] = 1'b0;
    @(negedge clk);
    check("fr_wr_low", 32'(ifa.wr_n_out), 32'd0);
    ifa.req[0] = 1'b0;
    @(negedge clk);
    check("fr_wr_forced", 32'(ifa.wr_n_out), 32'd1);
    check("fr_gnt0", 32'(ifa.gnt), 32'd0);
    ifa.wr_n_in[0] = 1'b1;
    wait_idle_a("fr_idle");
    check("fr_viol", 32'(ifa.viol), 32'd0);

    // Non-owner drives a strobe
    ifa.req = 2'b01;
    wait_gnt_a("vi_gnt", 2'b01);
    ifa.cs_n_in[0] = 1'b0;
    @(negedge clk);
    check("vi_pre", 32'(ifa.viol), 32'd0);
    ifa.rd_n_in[1] = 1'b0;
    @(negedge clk);
    check("vi_rd", 32'(ifa.rd_n_out), 32'd1);
    check("vi_cs", 32'(ifa.cs_n_out), 32'd0);
    check("vi_set", 32'(ifa.viol), 32'd1);
    ifa.rd_n_in[1] = 1'b1;
    ifa.cs_n_in[0] = 1'b1;
    ifa.req = 2'b00;
    wait_idle_a("vi_idle");
    check("vi_sticky", 32'(ifa.viol), 32'd1);

    // Owner drives RD and WR low together
    do_reset();
    check("bl_rst_viol", 32'(ifa.viol), 32'd0);
    ifa.req = 2'b01;
    wait_gnt_a("bl_gnt", 2'b01);
    ifa.rd_n_in[0] = 1'b0;
    ifa.wr_n_in[0] = 1'b0;
    @(negedge clk);
    check("bl_rd", 32'(ifa.rd_n_out), 32'd1);
    check("bl_wr", 32'(ifa.wr_n_out), 32'd1);
    check("bl_viol", 32'(ifa.viol), 32'd1);
    idle_a();
    wait_idle_a("bl_idle");

    // TURN=0, N_CH=4, req=1010
    do_reset();
    ifb.req = 4'b1010;
    @(negedge clk);
    check("b_first", 32'(ifb.gnt), 32'd2);
    ifb.req = 4'b1000;
    @(negedge clk);
    check("b_gap_gnt", 32'(ifb.gnt), 32'd0);
    check("b_gap_state", 32'(ifb.dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    check("b_second", 32'(ifb.gnt), 32'd8);
    ifb.req = 4'b0000;
    @(negedge clk);
    check("b_rel_gnt", 32'(ifb.gnt), 32'd0);
    check("b_rel_busy", 32'(ifb.busy), 32'd0);
    check("b_viol", 32'(ifb.viol), 32'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "time limit");
  end

endmodule
